// File: rtl/data_ram.sv
// Byte-addressed little-endian load/store RAM; response LATENCY cycles after acceptance, one access in flight.
// req_ready drops until the response is consumed; DATA_RAM_MISALIGN_TRAP_EN rejects misaligned half/word accesses.
module data_ram #(
  parameter int    DEPTH_BYTES = 65536,
  parameter int    LATENCY     = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_req_ready;
  logic            r_resp_valid;
  logic [31:0]     r_rdata;
  logic            r_err;
  logic            r_we;
  logic [1:0]      r_size;
  logic            r_uns;
  logic [AW-1:0]   r_base;
  logic [7:0]      r_mem [DEPTH_BYTES];

  logic            w_idle;
  logic            w_we;
  logic [1:0]      w_size;
  logic            w_uns;
  logic [AW-1:0]   w_base;
  logic [AW-1:0]   w_idx [4];
  logic [7:0]      w_byte [4];
  logic            w_misalign;
  logic            w_err;
  logic [31:0]     w_ld_data;
  logic [31:0]     w_resp_data;
  logic            w_wr_en;
  logic            w_unused_addr;

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  assign w_unused_addr = |req_addr[31:AW];

  // In IDLE the live request is decoded (store commit, LATENCY==1 load); afterwards the captured copy.
  assign w_idle = (r_state == S_IDLE);
  assign w_we   = w_idle ? req_we               : r_we;
  assign w_size = w_idle ? req_size             : r_size;
  assign w_uns  = w_idle ? req_unsigned         : r_uns;
  assign w_base = w_idle ? req_addr[AW-1:0]     : r_base;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_idx[k]  = w_base + AW'(k);
      w_byte[k] = r_mem[w_idx[k]];
    end
  end

`ifdef DATA_RAM_MISALIGN_TRAP_EN
  assign w_misalign = ((w_size == 2'b01) && w_base[0]) ||
                      ((w_size == 2'b10) && (w_base[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_err = (w_size == 2'b11) || w_misalign;

  always_comb begin
    w_ld_data = 32'h0;
    case (w_size)
      2'b00: w_ld_data = w_uns ? {24'h0, w_byte[0]} : {{24{w_byte[0][7]}}, w_byte[0]};
      2'b01: w_ld_data = w_uns ? {16'h0, w_byte[1], w_byte[0]}
                               : {{16{w_byte[1][7]}}, w_byte[1], w_byte[0]};
      2'b10: w_ld_data = {w_byte[3], w_byte[2], w_byte[1], w_byte[0]};
      default: w_ld_data = 32'h0;
    endcase
  end

  assign w_resp_data = (w_we || w_err) ? 32'h0 : w_ld_data;
  assign w_wr_en     = w_idle && r_req_ready && req_valid && req_we && !w_err;

  // Memory is deliberately outside the reset domain so committed stores survive a reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_idx[0]] <= req_wdata[7:0];
      if (req_size != 2'b00) begin
        r_mem[w_idx[1]] <= req_wdata[15:8];
      end
      if (req_size == 2'b10) begin
        r_mem[w_idx[2]] <= req_wdata[23:16];
        r_mem[w_idx[3]] <= req_wdata[31:24];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_rdata      <= 32'h0;
      r_err        <= 1'b0;
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_uns        <= 1'b0;
      r_base       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_size      <= req_size;
            r_uns       <= req_unsigned;
            r_base      <= req_addr[AW-1:0];
            r_cnt       <= CW'(LATENCY - 1);
            r_req_ready <= 1'b0;
            if (LATENCY == 1) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_rdata      <= w_resp_data;
              r_err        <= w_err;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_rdata      <= w_resp_data;
            r_err        <= w_err;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram.sv
// Bench for data_ram: instance A (LATENCY 1, 64 KiB) and instance B (LATENCY 3, 4 KiB).
module tb_data_ram;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam int DEP_A = 65536;
  localparam int DEP_B = 4096;

  logic        clk = 1'b0;
  logic        rst_n        [2];
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_we       [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [31:0] req_addr     [2];
  logic [31:0] req_wdata    [2];
  logic        resp_valid   [2];
  logic        resp_ready   [2];
  logic [31:0] resp_rdata   [2];
  logic        resp_err     [2];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mdl [2][65536];

  typedef struct {
    int          d;
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  vec_t vecs [19];

  data_ram #(.DEPTH_BYTES(DEP_A), .LATENCY(LAT_A), .INIT_FILE("")) u_dut_a (
    .clk(clk), .rst_n(rst_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  data_ram #(.DEPTH_BYTES(DEP_B), .LATENCY(LAT_B), .INIT_FILE("")) u_dut_b (
    .clk(clk), .rst_n(rst_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  always #5 clk = ~clk;

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT_A : LAT_B;
  endfunction

  function automatic longint depth_of(input int d);
    return (d == 0) ? longint'(DEP_A) : longint'(DEP_B);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: bytes at (addr+k) mod depth, little-endian, extension by arithmetic.
  task automatic model_op(input int d, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] exp_rd, output logic exp_er);
    longint dep  = depth_of(d);
    longint base = longint'(addr) % dep;
    int     n    = 1 << sz;
    longint v    = 0;
    exp_er = (sz == 2'b11);
`ifdef DATA_RAM_MISALIGN_TRAP_EN
    if (!exp_er && n > 1 && (longint'(addr) % n) != 0) exp_er = 1'b1;
`endif
    exp_rd = 32'h0;
    if (!exp_er) begin
      if (we) begin
        for (int k = 0; k < n; k++) mdl[d][int'((base + k) % dep)] = 8'(wd >> (8 * k));
      end else begin
        for (int k = 0; k < n; k++) v += longint'(mdl[d][int'((base + k) % dep)]) << (8 * k);
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        exp_rd = v[31:0];
      end
    end
  endtask

  task automatic access(input string nm, input int d, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input int hold, input logic [31:0] exp_rd, input logic exp_er);
    int lat;
    int waitc;
    @(posedge clk); #1;
    req_we[d] = we; req_size[d] = sz; req_unsigned[d] = uns;
    req_addr[d] = addr; req_wdata[d] = wd; req_valid[d] = 1'b1; resp_ready[d] = 1'b0;
    waitc = 0;
    while (!req_ready[d] && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    check({nm, "/req_ready_idle"}, 32'(req_ready[d]), 32'd1);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = 1;
    while (!resp_valid[d] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "/latency"}, 32'(lat), 32'(lat_of(d)));
    check({nm, "/rdata"}, resp_rdata[d], exp_rd);
    check({nm, "/err"}, 32'(resp_err[d]), 32'(exp_er));
    check({nm, "/req_ready_busy"}, 32'(req_ready[d]), 32'd0);
    for (int i = 0; i < hold; i++) begin
      req_valid[d] = 1'b1; req_we[d] = 1'b1; req_size[d] = 2'b10;
      req_addr[d] = addr; req_wdata[d] = ~wd;
      @(posedge clk); #1;
      check({nm, "/hold_valid"}, 32'(resp_valid[d]), 32'd1);
      check({nm, "/hold_rdata"}, resp_rdata[d], exp_rd);
      check({nm, "/hold_err"}, 32'(resp_err[d]), 32'(exp_er));
      check({nm, "/hold_req_ready"}, 32'(req_ready[d]), 32'd0);
    end
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
    req_valid[d]  = 1'b0;
    check({nm, "/post_valid"}, 32'(resp_valid[d]), 32'd0);
    check({nm, "/post_ready"}, 32'(req_ready[d]), 32'd1);
  endtask

  task automatic reset_in_wait(input string nm, input logic we, input logic [31:0] addr,
                               input logic [31:0] wd);
    @(posedge clk); #1;
    req_we[1] = we; req_size[1] = 2'b10; req_unsigned[1] = 1'b0;
    req_addr[1] = addr; req_wdata[1] = wd; req_valid[1] = 1'b1; resp_ready[1] = 1'b0;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    check({nm, "/wait_ready"}, 32'(req_ready[1]), 32'd0);
    check({nm, "/wait_valid"}, 32'(resp_valid[1]), 32'd0);
    rst_n[1] = 1'b0;
    #2;
    rst_n[1] = 1'b1;
    @(posedge clk); #1;
    check({nm, "/rel_ready"}, 32'(req_ready[1]), 32'd1);
    check({nm, "/rel_valid"}, 32'(resp_valid[1]), 32'd0);
    check({nm, "/rel_rdata"}, resp_rdata[1], 32'h0);
    check({nm, "/rel_err"}, 32'(resp_err[1]), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check({nm, "/discarded"}, 32'(resp_valid[1]), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] erd;
    logic        eer;
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;

    vecs[0]  = '{0, 1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{0, 1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{0, 1'b0, 2'd0, 1'b1, 32'h0000_0100, 32'h0,         32'h0000_00EF, 1'b0};
    vecs[3]  = '{0, 1'b1, 2'd0, 1'b0, 32'h0000_0020, 32'h0000_0080, 32'h0000_0000, 1'b0};
    vecs[4]  = '{0, 1'b0, 2'd0, 1'b0, 32'h0000_0020, 32'h0,         32'hFFFF_FF80, 1'b0};
    vecs[5]  = '{0, 1'b0, 2'd0, 1'b1, 32'h0000_0020, 32'h0,         32'h0000_0080, 1'b0};
    vecs[6]  = '{0, 1'b1, 2'd1, 1'b0, 32'h0000_0022, 32'h0000_8001, 32'h0000_0000, 1'b0};
    vecs[7]  = '{0, 1'b0, 2'd1, 1'b0, 32'h0000_0022, 32'h0,         32'hFFFF_8001, 1'b0};
    vecs[8]  = '{0, 1'b0, 2'd1, 1'b1, 32'h0000_0022, 32'h0,         32'h0000_8001, 1'b0};
    vecs[9]  = '{0, 1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'h1122_3344, 32'h0000_0000, 1'b0};
    vecs[10] = '{0, 1'b1, 2'd2, 1'b0, 32'h0000_0104, 32'h5566_7788, 32'h0000_0000, 1'b0};
`ifdef DATA_RAM_MISALIGN_TRAP_EN
    vecs[11] = '{0, 1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0,         32'h0000_0000, 1'b1};
`else
    vecs[11] = '{0, 1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0,         32'h8811_2233, 1'b0};
`endif
    vecs[12] = '{0, 1'b1, 2'd2, 1'b0, 32'h0000_0040, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
    vecs[13] = '{0, 1'b1, 2'd3, 1'b0, 32'h0000_0040, 32'h1234_5678, 32'h0000_0000, 1'b1};
    vecs[14] = '{0, 1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[15] = '{0, 1'b0, 2'd3, 1'b1, 32'h0000_0040, 32'h0,         32'h0000_0000, 1'b1};
    vecs[16] = '{1, 1'b1, 2'd2, 1'b0, 32'h0000_1000, 32'hA5A5_1234, 32'h0000_0000, 1'b0};
    vecs[17] = '{1, 1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_1234, 1'b0};
    vecs[18] = '{1, 1'b0, 2'd0, 1'b0, 32'hABCD_1003, 32'h0,         32'hFFFF_FFA5, 1'b0};

    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'b00;
      req_unsigned[d] = 1'b0; req_addr[d] = 32'h0; req_wdata[d] = 32'h0; resp_ready[d] = 1'b0;
    end
    #23;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset%0d/req_ready", d), 32'(req_ready[d]), 32'd1);
      check($sformatf("reset%0d/resp_valid", d), 32'(resp_valid[d]), 32'd0);
      check($sformatf("reset%0d/resp_rdata", d), resp_rdata[d], 32'h0);
      check($sformatf("reset%0d/resp_err", d), 32'(resp_err[d]), 32'd0);
    end

    for (int i = 0; i < 19; i++) begin
      access($sformatf("vec%0d", i), vecs[i].d, vecs[i].we, vecs[i].sz, vecs[i].uns,
             vecs[i].addr, vecs[i].wd, 0, vecs[i].exp_rd, vecs[i].exp_er);
    end

    // Response held for 4 cycles while a competing store is presented; it must not land.
    access("hold_lw", 1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 4, 32'hA5A5_1234, 1'b0);
    access("after_hold", 1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0, 32'hA5A5_1234, 1'b0);

    reset_in_wait("rst_store", 1'b1, 32'h8, 32'h0BAD_CAFE);
    access("store_kept", 1, 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 0, 32'h0BAD_CAFE, 1'b0);
    reset_in_wait("rst_load", 1'b0, 32'h0, 32'h0);
    access("after_rst_load", 1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0, 32'hA5A5_1234, 1'b0);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        addr = 32'h200 + 32'(4 * i);
        wd   = $urandom;
        model_op(d, 1'b1, 2'd2, 1'b0, addr, wd, erd, eer);
        access($sformatf("init%0d_%0d", d, i), d, 1'b1, 2'd2, 1'b0, addr, wd, 0, erd, eer);
      end
      for (int i = 0; i < 60; i++) begin
        we   = 1'($urandom_range(0, 1));
        sz   = 2'($urandom_range(0, 3));
        uns  = 1'($urandom_range(0, 1));
        addr = 32'(longint'(32'h200 + $urandom_range(0, 59)) +
                   depth_of(d) * longint'($urandom_range(0, 15)));
        wd   = $urandom;
        model_op(d, we, sz, uns, addr, wd, erd, eer);
        access($sformatf("rnd%0d_%0d", d, i), d, we, sz, uns, addr, wd,
               int'($urandom_range(0, 2)), erd, eer);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
